// File: rtl/imem_loader.sv
// Instruction-memory loader: turns a length-prefixed, XOR-checksummed byte
// stream into 32-bit word writes starting at address 0, stalling fetch meanwhile.
module imem_loader #(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  in_valid,
  input  logic [7:0]            in_data,
  output logic                  in_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic                  core_stall,
  output logic                  load_done,
  output logic                  load_error,
  output logic [1:0]            err_code,
  output logic [ADDR_WIDTH:0]   words_loaded
);

  typedef enum logic [2:0] {
    IDLE, LEN_LO, LEN_HI, DATA, WRITE, CSUM, DONE, ERROR
  } state_t;

  localparam logic [16:0] CAPACITY = 17'(1) << ADDR_WIDTH;

  state_t                state, state_next;
  logic [15:0]           len, len_next;
  logic [1:0]            byte_cnt, byte_cnt_next;
  logic [31:0]           word, word_next;
  logic [7:0]            csum, csum_next;
  logic                  in_ready_next, mem_we_next, core_stall_next;
  logic                  load_done_next, load_error_next;
  logic [ADDR_WIDTH-1:0] mem_addr_next;
  logic [31:0]           mem_wdata_next;
  logic [1:0]            err_code_next;
  logic [ADDR_WIDTH:0]   words_loaded_next;
  logic                  accept;
  logic [16:0]           len_full;

  assign accept   = in_valid && in_ready;
  assign len_full = {1'b0, in_data, len[7:0]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      len          <= '0;
      byte_cnt     <= '0;
      word         <= '0;
      csum         <= '0;
      in_ready     <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      core_stall   <= 1'b0;
      load_done    <= 1'b0;
      load_error   <= 1'b0;
      err_code     <= '0;
      words_loaded <= '0;
    end else begin
      state        <= state_next;
      len          <= len_next;
      byte_cnt     <= byte_cnt_next;
      word         <= word_next;
      csum         <= csum_next;
      in_ready     <= in_ready_next;
      mem_we       <= mem_we_next;
      mem_addr     <= mem_addr_next;
      mem_wdata    <= mem_wdata_next;
      core_stall   <= core_stall_next;
      load_done    <= load_done_next;
      load_error   <= load_error_next;
      err_code     <= err_code_next;
      words_loaded <= words_loaded_next;
    end
  end

  always_comb begin
    state_next        = state;
    len_next          = len;
    byte_cnt_next     = byte_cnt;
    word_next         = word;
    csum_next         = csum;
    mem_we_next       = 1'b0;
    mem_addr_next     = mem_addr;
    mem_wdata_next    = mem_wdata;
    err_code_next     = err_code;
    words_loaded_next = words_loaded;

    case (state)
      IDLE, DONE, ERROR: begin
        if (start) begin
          state_next        = LEN_LO;
          err_code_next     = 2'b00;
          words_loaded_next = '0;
          csum_next         = '0;
          byte_cnt_next     = '0;
        end
      end
      LEN_LO: begin
        if (accept) begin
          len_next[7:0] = in_data;
          csum_next     = csum ^ in_data;
          state_next    = LEN_HI;
        end
      end
      LEN_HI: begin
        if (accept) begin
          len_next[15:8] = in_data;
          csum_next      = csum ^ in_data;
          byte_cnt_next  = '0;
          if (len_full > CAPACITY) begin
            state_next    = ERROR;
            err_code_next = 2'b01;
          end else if (len_full == 17'd0) begin
            state_next = CSUM;
          end else begin
            state_next = DATA;
          end
        end
      end
      DATA: begin
        if (accept) begin
          word_next[{byte_cnt, 3'b000} +: 8] = in_data;
          csum_next     = csum ^ in_data;
          byte_cnt_next = byte_cnt + 2'd1;
          if (byte_cnt == 2'd3) begin
            // Write strobe is registered, so it is launched here to land in WRITE.
            state_next     = WRITE;
            mem_we_next    = 1'b1;
            mem_addr_next  = words_loaded[ADDR_WIDTH-1:0];
            mem_wdata_next = word_next;
          end
        end
      end
      WRITE: begin
        words_loaded_next = words_loaded + 1'b1;
        if ((17'(words_loaded) + 17'd1) == {1'b0, len})
          state_next = CSUM;
        else
          state_next = DATA;
      end
      CSUM: begin
        if (accept) begin
          if (in_data == csum) begin
            state_next = DONE;
          end else begin
            state_next    = ERROR;
            err_code_next = 2'b10;
          end
        end
      end
      default: state_next = IDLE;
    endcase

    in_ready_next   = (state_next == LEN_LO) || (state_next == LEN_HI) ||
                      (state_next == DATA)   || (state_next == CSUM);
    core_stall_next = in_ready_next || (state_next == WRITE);
    load_done_next  = (state_next == DONE);
    load_error_next = (state_next == ERROR);
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed and random byte-stream sessions
// compared against a stream-parsing reference model.
module tb_imem_loader;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          reset, start, in_valid;
  logic [7:0]    in_data;
  logic          in_ready, mem_we, core_stall, load_done, load_error;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [1:0]    err_code;
  logic [AW:0]   words_loaded;

  imem_loader #(.ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid),
    .in_data(in_data), .in_ready(in_ready), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .core_stall(core_stall),
    .load_done(load_done), .load_error(load_error), .err_code(err_code),
    .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0]    stream[$];
  logic [AW-1:0] got_addr[$];
  logic [31:0]   got_data[$];
  logic [AW-1:0] exp_addr[$];
  logic [31:0]   exp_data[$];
  bit            exp_done;
  logic [1:0]    exp_code;
  int            exp_words;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mem_we) begin
      got_addr.push_back(mem_addr);
      got_data.push_back(mem_wdata);
    end
  end

  // Reference model: parse the stream exactly as the format describes it.
  task automatic build_expect();
    int n;
    logic [7:0] x;
    exp_addr.delete();
    exp_data.delete();
    n = int'({stream[1], stream[0]});
    if (n > (1 << AW)) begin
      exp_done = 0; exp_code = 2'b01; exp_words = 0;
      return;
    end
    x = 8'h00;
    for (int i = 0; i < 2 + 4 * n; i++) x ^= stream[i];
    for (int w = 0; w < n; w++) begin
      exp_addr.push_back(AW'(w));
      exp_data.push_back({stream[2+4*w+3], stream[2+4*w+2], stream[2+4*w+1], stream[2+4*w]});
    end
    exp_words = n;
    if (stream[2 + 4 * n] == x) begin
      exp_done = 1; exp_code = 2'b00;
    end else begin
      exp_done = 0; exp_code = 2'b10;
    end
  endtask

  task automatic make_random(input int n, input bit good);
    logic [7:0] x;
    logic [7:0] b;
    stream.delete();
    stream.push_back(8'(n));
    stream.push_back(8'(n >> 8));
    if (n > (1 << AW)) return;
    x = stream[0] ^ stream[1];
    for (int i = 0; i < 4 * n; i++) begin
      b = 8'($urandom);
      stream.push_back(b);
      x ^= b;
    end
    stream.push_back(good ? x : (x ^ 8'($urandom_range(1, 255))));
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_session(input string name, input int valid_pct, input int extra_start_at);
    int idx;
    int cyc;
    bit acc;
    build_expect();
    got_addr.delete();
    got_data.delete();
    pulse_start();
    check({name, ":stall_after_start"}, core_stall, 1'b1);
    check({name, ":ready_after_start"}, in_ready, 1'b1);
    idx = 0;
    cyc = 0;
    while (idx < stream.size() && cyc < 20000) begin
      in_valid = ($urandom_range(0, 99) < valid_pct);
      in_data  = in_valid ? stream[idx] : 8'($urandom);
      start    = (cyc == extra_start_at);
      acc      = in_valid && in_ready;
      @(negedge clk);
      if (acc) idx++;
      cyc++;
    end
    in_valid = 1'b0;
    start    = 1'b0;
    if (cyc >= 20000) check({name, ":stream_timeout"}, idx, stream.size());
    for (int k = 0; k < 20 && !(load_done || load_error); k++) @(negedge clk);
    check({name, ":finished"}, load_done | load_error, 1'b1);
    check({name, ":load_done"}, load_done, exp_done);
    check({name, ":load_error"}, load_error, !exp_done);
    check({name, ":err_code"}, err_code, exp_code);
    check({name, ":words_loaded"}, words_loaded, exp_words);
    check({name, ":core_stall_end"}, core_stall, 1'b0);
    check({name, ":in_ready_end"}, in_ready, 1'b0);
    check({name, ":write_count"}, got_addr.size(), exp_addr.size());
    for (int i = 0; i < exp_addr.size() && i < got_addr.size(); i++) begin
      check({name, ":wr_addr"}, got_addr[i], exp_addr[i]);
      check({name, ":wr_data"}, got_data[i], exp_data[i]);
    end
    $display("session %s: bytes=%0d writes=%0d done=%0b error=%0b err_code=%0d words=%0d",
             name, stream.size(), got_addr.size(), load_done, load_error, err_code, words_loaded);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    repeat (3) @(negedge clk);
    check("reset:in_ready", in_ready, 1'b0);
    check("reset:mem_we", mem_we, 1'b0);
    check("reset:core_stall", core_stall, 1'b0);
    check("reset:done_err", {load_done, load_error, err_code}, 4'b0);
    check("reset:words", words_loaded, 0);
    reset = 1'b0;
    @(negedge clk);

    stream = '{8'h02, 8'h00, 8'h20, 8'h18, 8'h22, 8'h00, 8'h22, 8'h28, 8'h83, 8'h00, 8'h91};
    run_session("two_words", 100, -1);
    if (got_data.size() == 2) begin
      check("two_words:word0", got_data[0], 32'h00221820);
      check("two_words:word1", got_data[1], 32'h00832822);
    end

    stream = '{8'h02, 8'h00, 8'h20, 8'h18, 8'h22, 8'h00, 8'h22, 8'h28, 8'h83, 8'h00, 8'h90};
    run_session("bad_csum", 100, -1);

    stream = '{8'h01, 8'h01};
    run_session("len_257", 100, -1);

    stream = '{8'h00, 8'h00, 8'h00};
    run_session("len_zero", 100, -1);

    stream = '{8'h02, 8'h00, 8'h20, 8'h18, 8'h22, 8'h00, 8'h22, 8'h28, 8'h83, 8'h00, 8'h91};
    run_session("gappy_extra_start", 60, 7);

    // Reset after the sixth byte, then a fresh full load.
    pulse_start();
    in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in_data = stream[i];
      @(negedge clk);
    end
    in_valid = 1'b0;
    reset = 1'b1;
    #1;
    check("midreset:outputs", {in_ready, mem_we, core_stall, load_done, load_error, err_code}, 7'b0);
    check("midreset:words", words_loaded, 0);
    check("midreset:addr_data", {mem_addr, mem_wdata}, 40'b0);
    @(negedge clk);
    reset = 1'b0;
    run_session("after_reset", 100, -1);

    for (int s = 0; s < 8; s++) begin
      make_random($urandom_range(0, 8), $urandom_range(0, 3) != 0);
      run_session($sformatf("rand%0d", s), $urandom_range(40, 100), $urandom_range(0, 30));
    end
    make_random(256, 1'b1);
    run_session("full_capacity", 90, -1);
    make_random($urandom_range(257, 65535), 1'b1);
    run_session("oversize", 100, -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
